// File: rtl/mem_access_unit.sv
// MEM stage: issues one bus transaction per load/store, extracts big-endian
// load data, and aborts with bus_err if mem_ack does not arrive within TIMEOUT.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_out_alu_ex_mm,
  input  logic [31:0] rd1_data_ex_mm,
  input  logic [1:0]  dm_access_sz_ex_mm,
  input  logic        dm_rw_ex_mm,
  input  logic [31:0] pc_ex_mm,
  input  logic        wr_en_reg_ex_mm,
  input  logic [4:0]  wr_num_ex_mm,
  input  logic [5:0]  opcode_ex_mm,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_mm,
  output logic [31:0] data_out_mm_wb,
  output logic [31:0] pc_mm_wb,
  output logic        wr_en_reg_mm_wb,
  output logic [4:0]  wr_num_mm_wb,
  output logic        misalign_mm_wb,
  output logic        bus_err_mm_wb
);
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  sz_q, sz_d, off_q, off_d;
  logic        sign_q, sign_d, wren_lat_q, wren_lat_d;
  logic [31:0] pc_lat_q, pc_lat_d;
  logic [4:0]  num_lat_q, num_lat_d;
  logic [31:0] wb_data_q, wb_data_d, wb_pc_q, wb_pc_d;
  logic        wb_wren_q, wb_wren_d, wb_mis_q, wb_mis_d, wb_err_q, wb_err_d;
  logic [4:0]  wb_num_q, wb_num_d;

  logic        is_mem, is_byte, is_half, is_word, misalign, stall_c;
  logic [1:0]  a_lo;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_mem  = opcode_ex_mm inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    a_lo    = data_out_alu_ex_mm[1:0];
    is_byte = (dm_access_sz_ex_mm == 2'b10);
    is_half = (dm_access_sz_ex_mm == 2'b01);
    is_word = !is_byte && !is_half;
    misalign = is_mem && ((is_half && a_lo[0]) || (is_word && (a_lo != 2'b00)));
    // Big-endian lanes: offset 0 is the most significant byte.
    if (is_byte) begin
      be_new    = 4'b1000 >> a_lo;
      wdata_new = {4{rd1_data_ex_mm[7:0]}};
    end else if (is_half) begin
      be_new    = a_lo[1] ? 4'b0011 : 4'b1100;
      wdata_new = {2{rd1_data_ex_mm[15:0]}};
    end else begin
      be_new    = 4'b1111;
      wdata_new = rd1_data_ex_mm;
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[31:24];
      2'd1:    ld_byte = mem_rdata[23:16];
      2'd2:    ld_byte = mem_rdata[15:8];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    if (sz_q == 2'b10)      ld_data = {{24{sign_q & ld_byte[7]}}, ld_byte};
    else if (sz_q == 2'b01) ld_data = {{16{sign_q & ld_half[15]}}, ld_half};
    else                    ld_data = mem_rdata;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    sz_d       = sz_q;
    off_d      = off_q;
    sign_d     = sign_q;
    wren_lat_d = wren_lat_q;
    pc_lat_d   = pc_lat_q;
    num_lat_d  = num_lat_q;
    wb_data_d  = '0;
    wb_pc_d    = '0;
    wb_wren_d  = 1'b0;
    wb_num_d   = '0;
    wb_mis_d   = 1'b0;
    wb_err_d   = 1'b0;
    stall_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!is_mem) begin
          wb_data_d = data_out_alu_ex_mm;
          wb_pc_d   = pc_ex_mm;
          wb_wren_d = wr_en_reg_ex_mm;
          wb_num_d  = wr_num_ex_mm;
        end else if (misalign) begin
          wb_pc_d  = pc_ex_mm;
          wb_num_d = wr_num_ex_mm;
          wb_mis_d = 1'b1;
        end else begin
          stall_c    = 1'b1;
          state_d    = ACCESS;
          cnt_d      = 8'd1;
          req_d      = 1'b1;
          we_d       = dm_rw_ex_mm;
          addr_d     = {data_out_alu_ex_mm[31:2], 2'b00};
          be_d       = be_new;
          wdata_d    = wdata_new;
          sz_d       = dm_access_sz_ex_mm;
          off_d      = a_lo;
          sign_d     = (opcode_ex_mm == 6'h20) || (opcode_ex_mm == 6'h21);
          wren_lat_d = wr_en_reg_ex_mm;
          pc_lat_d   = pc_ex_mm;
          num_lat_d  = wr_num_ex_mm;
        end
      end
      ACCESS: begin
        if (mem_ack || cnt_q >= TO_CNT) begin
          state_d  = IDLE;
          cnt_d    = '0;
          req_d    = 1'b0;
          we_d     = 1'b0;
          wb_pc_d  = pc_lat_q;
          wb_num_d = num_lat_q;
          // A coincident ack wins over the timeout.
          if (mem_ack) begin
            wb_data_d = we_q ? '0 : ld_data;
            wb_wren_d = !we_q && wren_lat_q;
          end else begin
            wb_err_d = 1'b1;
          end
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      sz_q       <= '0;
      off_q      <= '0;
      sign_q     <= 1'b0;
      wren_lat_q <= 1'b0;
      pc_lat_q   <= '0;
      num_lat_q  <= '0;
      wb_data_q  <= '0;
      wb_pc_q    <= '0;
      wb_wren_q  <= 1'b0;
      wb_num_q   <= '0;
      wb_mis_q   <= 1'b0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      sz_q       <= sz_d;
      off_q      <= off_d;
      sign_q     <= sign_d;
      wren_lat_q <= wren_lat_d;
      pc_lat_q   <= pc_lat_d;
      num_lat_q  <= num_lat_d;
      wb_data_q  <= wb_data_d;
      wb_pc_q    <= wb_pc_d;
      wb_wren_q  <= wb_wren_d;
      wb_num_q   <= wb_num_d;
      wb_mis_q   <= wb_mis_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign stall_mm        = stall_c && !rst;
  assign mem_req         = req_q;
  assign mem_we          = we_q;
  assign mem_addr        = addr_q;
  assign mem_be          = be_q;
  assign mem_wdata       = wdata_q;
  assign data_out_mm_wb  = wb_data_q;
  assign pc_mm_wb        = wb_pc_q;
  assign wr_en_reg_mm_wb = wb_wren_q;
  assign wr_num_mm_wb    = wb_num_q;
  assign misalign_mm_wb  = wb_mis_q;
  assign bus_err_mm_wb   = wb_err_q;
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, 16, max ACCESS cycles without mem_ack before abort (legal range 2..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 data_out_alu_ex_mm  in  32  effective address, or ALU result for non-memory ops.
REQ-005 rd1_data_ex_mm  in  32  store data.
REQ-006 dm_access_sz_ex_mm  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-007 dm_rw_ex_mm  in  1  1 = store, 0 = load.
REQ-008 pc_ex_mm, wr_en_reg_ex_mm, wr_num_ex_mm, opcode_ex_mm  in  32/1/5/6  EX/MEM fields.
REQ-009 mem_req, mem_we  out  1/1  bus request (level, held until ack or abort); write enable.
REQ-010 mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-011 mem_be, mem_wdata  out  4/32  byte enables (bit3 = bits 31:24), lane-placed store data.
REQ-012 mem_ack, mem_rdata  in  1/32  one-cycle completion strobe; read data valid with ack.
REQ-013 stall_mm  out  1  combinational; upstream holds EX/MEM stable while high.
REQ-014 data_out_mm_wb, pc_mm_wb, wr_en_reg_mm_wb, wr_num_mm_wb  out  32/32/1/5  registered MEM/WB fields.
REQ-015 misalign_mm_wb, bus_err_mm_wb  out  1/1  registered fault flags for the retiring instruction.

Function
REQ-016 Memory op SHALL mean opcode in {0x20 lb,0x21 lh,0x23 lw,0x24 lbu,0x25 lhu,0x28 sb,0x29 sh,0x2B sw}; all else is non-memory.
REQ-017 Byte order SHALL be big-endian: addr[1:0]=00 selects bits 31:24, 11 selects bits 7:0; half at addr[1]=0 selects bits 31:16.
REQ-018 Misaligned SHALL mean half with addr[0]=1 or word with addr[1:0]!=00.
REQ-019 FSM states SHALL be IDLE and ACCESS only.
REQ-020 IDLE, non-memory op: stall_mm=0; next edge MEM/WB <= {data_out_alu, pc, wr_en, wr_num}, flags 0.
REQ-021 IDLE, misaligned memory op: no request, stall_mm=0; next edge MEM/WB <= pc, wr_num, wr_en=0, data=0, misalign=1.
REQ-022 IDLE, aligned memory op: stall_mm=1; next edge -> ACCESS, latch address, be, wdata, size, sign, pc, wr_num, wr_en; MEM/WB loads bubble (all zero).
REQ-023 ACCESS: mem_req=1 from latched registers; mem_we=1 for stores; stall_mm = !mem_ack.
REQ-024 Byte store SHALL replicate rd1[7:0] to all lanes with one-hot be; half store replicates rd1[15:0] with be 1100/0011; word be 1111.
REQ-025 Load be SHALL equal the store encoding for the same size/address (reads ignore be semantically).
REQ-026 ACCESS with mem_ack: next edge -> IDLE; MEM/WB <= extracted load data (lb/lh sign-extend, lbu/lhu zero-extend, lw as-is), or data=0 and wr_en=0 for stores; flags 0.
REQ-027 ACCESS without ack: MEM/WB loads bubble; cycle counter increments from 1 on ACCESS entry.
REQ-028 Counter reaching TIMEOUT without ack: stall_mm=0 that cycle; next edge -> IDLE, mem_req drops, MEM/WB <= pc, wr_num, wr_en=0, bus_err=1.
REQ-029 mem_ack in IDLE SHALL be ignored; ack coincident with timeout SHALL count as success.
REQ-030 Back-to-back memory ops: new op accepted in IDLE the cycle after return; minimum 2 cycles per memory op, 1 per non-memory op.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, counter 0, every registered output 0 (mem_req, mem_we, mem_be, mem_addr, mem_wdata, all MEM/WB fields, flags), overriding any in-flight access.
REQ-032 During rst=1, stall_mm SHALL be 0; an ack arriving after reset abort is ignored.

Verification
REQ-033 sw addr 0x100 data 0x11223344, ack in 2nd ACCESS cycle -> mem_req high 2 cycles, be=1111, wdata=0x11223344, stall high 2 cycles, wr_en_reg_mm_wb=0.
REQ-034 lb addr 0x103, rdata 0x000000F0, wr_num 5 -> be=0001, data_out_mm_wb=0xFFFFFFF0, wr_en=1, wr_num=5.
REQ-035 lhu addr 0x102, rdata 0x1234ABCD -> be=0011, data_out_mm_wb=0x0000ABCD; lh same -> 0xFFFFABCD.
REQ-036 lw addr 0x102 -> no mem_req, stall never high, misalign_mm_wb=1, wr_en=0 next cycle.
REQ-037 lw, no ack for TIMEOUT=16 -> mem_req high exactly 16 cycles, bus_err_mm_wb=1, wr_en=0, FSM IDLE.
REQ-038 rst asserted mid-ACCESS cycle 3 -> next edge all outputs 0, IDLE; late ack ignored; following addu passes in 1 cycle.
